// File: rtl/apb_uart_pkg.sv
// Shared types for the UART engine: frame config, parity modes
// and the TX/RX state encodings.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } uart_tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } uart_rx_state_e;

    typedef struct packed {
        logic [3:0] data_bits;
        logic       parity_en;
        logic       parity_odd;
        logic       two_stop;
    } uart_frame_cfg_t;

    localparam logic [3:0] MIN_DATA_BITS = 4'd5;

    // Clamp the data width and split the parity mode into flags.
    function automatic uart_frame_cfg_t decode_cfg(
        input logic [3:0]   bits,
        input parity_mode_e par,
        input logic         stop,
        input logic [3:0]   max_bits
    );
        uart_frame_cfg_t cfg;
        if (bits < MIN_DATA_BITS) begin
            cfg.data_bits = MIN_DATA_BITS;
        end else if (bits > max_bits) begin
            cfg.data_bits = max_bits;
        end else begin
            cfg.data_bits = bits;
        end
        cfg.parity_en  = (par == PAR_EVEN) || (par == PAR_ODD);
        cfg.parity_odd = (par == PAR_ODD);
        cfg.two_stop   = stop;
        return cfg;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick enable: one pulse every div_i+1 clock cycles.
// The >= compare lets a lowered divider take effect at once.
module uart_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // Wrap the counter and fire the tick on the wrap cycle.
    always_comb begin
        tick_o = (cnt_q >= div_i);
        cnt_d  = tick_o ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_engine.sv
// Single-clock UART transmitter and receiver sharing one
// oversampling tick; frame format chosen per frame at run time.
module uart_engine
    import apb_uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic [DIV_WIDTH-1:0]     clk_div_i,
    input  logic [3:0]               data_bits_i,
    input  logic [1:0]               parity_mode_i,
    input  logic                     extra_stop_i,
    input  logic [MAX_DATA_BITS-1:0] tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic                     tx_o,
    output logic                     tx_busy_o,
    input  logic                     rx_i,
    output logic [MAX_DATA_BITS-1:0] rx_data_o,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    output logic                     rx_parity_err_o,
    output logic                     rx_frame_err_o,
    output logic                     rx_overrun_o
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] CNT_ONE = OSW'(1);
    localparam logic [3:0]     MAXB    = 4'(MAX_DATA_BITS);

    logic            tick;
    uart_frame_cfg_t cfg_in;

    uart_tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .div_i  (clk_div_i),
        .tick_o (tick)
    );

    // Decode the live frame configuration for both directions.
    always_comb begin
        cfg_in = decode_cfg(data_bits_i, parity_mode_e'(parity_mode_i),
                            extra_stop_i, MAXB);
    end

    uart_tx_state_e           tx_state_q, tx_state_d;
    uart_frame_cfg_t          tx_cfg_q, tx_cfg_d;
    logic                     tx_wait_q, tx_wait_d;
    logic [OSW-1:0]           tx_cnt_q, tx_cnt_d;
    logic [3:0]               tx_idx_q, tx_idx_d;
    logic [MAX_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                     tx_par_q, tx_par_d;
    logic                     tx_q, tx_d;
    logic                     tx_step;

    // TX next state: the line changes on the tick that starts each
    // bit; START waits for the first tick after the handshake.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cfg_d   = tx_cfg_q;
        tx_wait_d  = tx_wait_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_step    = tick && !tx_wait_q && (tx_cnt_q == OS_LAST);
        if (tick && !tx_wait_q && (tx_state_q != TX_IDLE)) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
        if (tx_step) begin
            tx_cnt_d = '0;
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid_i) begin
                    tx_cfg_d   = cfg_in;
                    tx_shift_d = tx_data_i &
                        ~({MAX_DATA_BITS{1'b1}} << cfg_in.data_bits);
                    tx_idx_d   = '0;
                    tx_par_d   = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                    tx_wait_d  = !tick;
                    if (tick) begin
                        tx_d = 1'b0;
                    end
                end
            end
            TX_START: begin
                if (tx_wait_q && tick) begin
                    tx_wait_d = 1'b0;
                    tx_d      = 1'b0;
                end else if (tx_step) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_step) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_par_d   = tx_par_q ^ tx_shift_q[0];
                    tx_idx_d   = tx_idx_q + 4'd1;
                    if (tx_idx_q == tx_cfg_q.data_bits - 4'd1) begin
                        if (tx_cfg_q.parity_en) begin
                            tx_state_d = TX_PARITY;
                            tx_d = tx_par_d ^ tx_cfg_q.parity_odd;
                        end else begin
                            tx_state_d = TX_STOP1;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_d = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_step) begin
                    tx_state_d = TX_STOP1;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP1: begin
                if (tx_step) begin
                    tx_state_d = tx_cfg_q.two_stop ? TX_STOP2 : TX_IDLE;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP2: begin
                if (tx_step) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cfg_q   <= '0;
            tx_wait_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cfg_q   <= tx_cfg_d;
            tx_wait_q  <= tx_wait_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = (tx_state_q == TX_IDLE);
    assign tx_busy_o  = (tx_state_q != TX_IDLE);

    uart_rx_state_e           rx_state_q, rx_state_d;
    logic                     rx_s1_q, rx_s1_d;
    logic                     rx_s2_q, rx_s2_d;
    logic                     rx_prev_q, rx_prev_d;
    logic [OSW-1:0]           rx_cnt_q, rx_cnt_d;
    logic [3:0]               rx_idx_q, rx_idx_d;
    logic [3:0]               rx_nbits_q, rx_nbits_d;
    logic                     rx_par_en_q, rx_par_en_d;
    logic                     rx_par_odd_q, rx_par_odd_d;
    logic                     rx_par_q, rx_par_d;
    logic                     rx_perr_q, rx_perr_d;
    logic [MAX_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [MAX_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     rx_perr_out_q, rx_perr_out_d;
    logic                     rx_ferr_q, rx_ferr_d;
    logic                     rx_ovr_q, rx_ovr_d;
    logic                     rx_fall;
    logic                     rx_sample;
    logic                     rx_load;

    // RX next state: sample mid-bit, shift data in from the top and
    // hand the word to the output register at the stop sample.
    always_comb begin
        rx_s1_d       = rx_i;
        rx_s2_d       = rx_s1_q;
        rx_prev_d     = rx_s2_q;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_idx_d      = rx_idx_q;
        rx_nbits_d    = rx_nbits_q;
        rx_par_en_d   = rx_par_en_q;
        rx_par_odd_d  = rx_par_odd_q;
        rx_par_d      = rx_par_q;
        rx_perr_d     = rx_perr_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_perr_out_d = rx_perr_out_q;
        rx_ferr_d     = rx_ferr_q;
        rx_ovr_d      = 1'b0;
        rx_fall       = rx_prev_q && !rx_s2_q;
        rx_sample     = tick && (rx_cnt_q ==
                        ((rx_state_q == RX_START) ? OS_MID : OS_LAST));
        rx_load       = !rx_valid_q || rx_ready_i;
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
        if (tick && (rx_state_q != RX_IDLE)) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
        if (rx_sample) begin
            rx_cnt_d = '0;
        end
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d   = RX_START;
                    rx_cnt_d     = '0;
                    rx_idx_d     = '0;
                    rx_nbits_d   = cfg_in.data_bits;
                    rx_par_en_d  = cfg_in.parity_en;
                    rx_par_odd_d = cfg_in.parity_odd;
                    rx_par_d     = 1'b0;
                    rx_perr_d    = 1'b0;
                    rx_shift_d   = '0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[MAX_DATA_BITS-1:1]};
                    rx_par_d   = rx_par_q ^ rx_s2_q;
                    rx_idx_d   = rx_idx_q + 4'd1;
                    if (rx_idx_q == rx_nbits_q - 4'd1) begin
                        rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = rx_par_q ^ rx_s2_q ^ rx_par_odd_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_d = RX_IDLE;
                    if (rx_load) begin
                        rx_valid_d    = 1'b1;
                        rx_data_d     = rx_shift_q >> (MAXB - rx_nbits_q);
                        rx_perr_out_d = rx_perr_q;
                        rx_ferr_d     = !rx_s2_q;
                    end else begin
                        rx_ovr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX registers, including the pin synchronizer.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_idx_q      <= '0;
            rx_nbits_q    <= MIN_DATA_BITS;
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_par_q      <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_ovr_q      <= 1'b0;
        end else begin
            rx_s1_q       <= rx_s1_d;
            rx_s2_q       <= rx_s2_d;
            rx_prev_q     <= rx_prev_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_idx_q      <= rx_idx_d;
            rx_nbits_q    <= rx_nbits_d;
            rx_par_en_q   <= rx_par_en_d;
            rx_par_odd_q  <= rx_par_odd_d;
            rx_par_q      <= rx_par_d;
            rx_perr_q     <= rx_perr_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_out_q <= rx_perr_out_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_ovr_q      <= rx_ovr_d;
        end
    end

    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_parity_err_o = rx_perr_out_q;
    assign rx_frame_err_o  = rx_ferr_q;
    assign rx_overrun_o    = rx_ovr_q;

endmodule

// File: tb/tb_uart_engine.sv
// Directed and randomized checks of uart_engine against a
// frame-level model of the serial format.
module tb_uart_engine;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [15:0] clk_div;
    logic [3:0]  data_bits;
    logic [1:0]  pmode;
    logic        extra_stop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_o;
    logic        tx_busy;
    logic        rx_drv;
    logic        loop_en;
    logic        rx_line;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        perr;
    logic        ferr;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    bit fb[$];

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_o : rx_drv;

    uart_engine #(
        .MAX_DATA_BITS(8),
        .OVERSAMPLE(16),
        .DIV_WIDTH(16)
    ) dut (
        .clk_i          (clk),
        .arst_ni        (arst_n),
        .clk_div_i      (clk_div),
        .data_bits_i    (data_bits),
        .parity_mode_i  (pmode),
        .extra_stop_i   (extra_stop),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy),
        .rx_i           (rx_line),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready),
        .rx_parity_err_o(perr),
        .rx_frame_err_o (ferr),
        .rx_overrun_o   (ovr)
    );

    // Count cycles in which the overrun pulse is high.
    always @(negedge clk) begin
        if (ovr === 1'b1) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_bits(input int b);
        if (b < 5) return 5;
        if (b > MAXB) return MAXB;
        return b;
    endfunction

    function automatic int exp_word(input int d, input int b);
        return d % (1 << eff_bits(b));
    endfunction

    // Whole frame as a bit list: start, data LSB first, parity, stops.
    function automatic void make_frame(input int d, input int b,
                                       input int pm, input bit two,
                                       input bit stop_val,
                                       input bit bad_par);
        int n;
        int ones;
        bit p;
        n = eff_bits(b);
        ones = $countones(exp_word(d, b));
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < n; i++) fb.push_back(bit'((d >> i) & 1));
        if (pm == 1 || pm == 2) begin
            p = (pm == 1) ? bit'(ones % 2) : bit'((ones + 1) % 2);
            fb.push_back(p ^ bad_par);
        end
        fb.push_back(stop_val);
        if (two) fb.push_back(1'b1);
    endfunction

    task automatic drive_frame(input int bit_cycles);
        foreach (fb[i]) begin
            rx_drv = fb[i];
            repeat (bit_cycles) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic send(input int d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = d[7:0];
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("pop_clears_valid", {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic loop_frame(input int d, input int b, input int pm,
                              input bit two, input string tag);
        data_bits  = 4'(b);
        pmode      = 2'(pm);
        extra_stop = two;
        send(d);
        wait_rx({tag, "_valid"});
        chk({tag, "_data"}, {24'd0, rx_data}, 32'(exp_word(d, b)));
        chk({tag, "_perr"}, {31'd0, perr}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
        pop();
    endtask

    initial begin
        int o0;
        arst_n     = 1'b0;
        clk_div    = 16'd0;
        data_bits  = 4'd8;
        pmode      = 2'b00;
        extra_stop = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_drv     = 1'b1;
        loop_en    = 1'b0;
        rx_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_o", {31'd0, tx_o}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_errs", {29'd0, perr, ferr, ovr}, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5 at one tick per cycle, checked every cycle.
        make_frame(8'hA5, 8, 0, 1'b0, 1'b1, 1'b0);
        send(8'hA5);
        chk("tx_first_edge", {31'd0, tx_o}, 32'd0);
        for (int c = 0; c < 160; c++) begin
            chk($sformatf("tx_a5_bit%0d", c / 16),
                {31'd0, tx_o}, {31'd0, fb[c / 16]});
            if (c == 80) chk("tx_busy_mid", {31'd0, tx_busy}, 32'd1);
            if (c == 159) chk("tx_ready_last", {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
        end
        chk("tx_ready_rise", {31'd0, tx_ready}, 32'd1);

        // Loopback 7E2 with a divided tick.
        loop_en = 1'b1;
        clk_div = 16'd3;
        loop_frame(8'h00, 7, 1, 1'b1, "lb7e2_00");
        loop_frame(8'h7F, 7, 1, 1'b1, "lb7e2_7f");
        loop_frame(8'h55, 7, 1, 1'b1, "lb7e2_55");

        // Random formats, including out-of-range widths.
        for (int k = 0; k < 10; k++) begin
            clk_div = 16'($urandom_range(0, 2));
            loop_frame(int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       $sformatf("lb_rand%0d", k));
        end

        // Injected frames: wrong parity, right parity, bad stop.
        loop_en   = 1'b0;
        clk_div   = 16'd0;
        data_bits = 4'd8;
        pmode     = 2'b10;
        repeat (20) @(negedge clk);
        make_frame(8'h01, 8, 2, 1'b0, 1'b1, 1'b1);
        drive_frame(16);
        repeat (4) @(negedge clk);
        chk("badpar_valid", {31'd0, rx_valid}, 32'd1);
        chk("badpar_perr", {31'd0, perr}, 32'd1);
        chk("badpar_data", {24'd0, rx_data}, 32'h01);
        pop();
        repeat (20) @(negedge clk);
        make_frame(8'h01, 8, 2, 1'b0, 1'b1, 1'b0);
        drive_frame(16);
        repeat (4) @(negedge clk);
        chk("goodpar_valid", {31'd0, rx_valid}, 32'd1);
        chk("goodpar_perr", {31'd0, perr}, 32'd0);
        pop();
        repeat (20) @(negedge clk);
        make_frame(8'h5A, 8, 2, 1'b0, 1'b0, 1'b0);
        drive_frame(16);
        repeat (4) @(negedge clk);
        chk("ferr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ferr_flag", {31'd0, ferr}, 32'd1);
        chk("ferr_data", {24'd0, rx_data}, 32'h5A);
        pop();

        // Short low glitch must not produce a word.
        pmode = 2'b00;
        repeat (20) @(negedge clk);
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        make_frame(8'h3C, 8, 0, 1'b0, 1'b1, 1'b0);
        drive_frame(16);
        repeat (4) @(negedge clk);
        chk("post_glitch_data", {24'd0, rx_data}, 32'h3C);
        pop();

        // Overrun: second word dropped while the first is unread.
        repeat (20) @(negedge clk);
        o0 = ovr_cnt;
        make_frame(8'h11, 8, 0, 1'b0, 1'b1, 1'b0);
        drive_frame(16);
        repeat (20) @(negedge clk);
        make_frame(8'h22, 8, 0, 1'b0, 1'b1, 1'b0);
        drive_frame(16);
        repeat (20) @(negedge clk);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_keep_data", {24'd0, rx_data}, 32'h11);
        chk("ovr_keep_valid", {31'd0, rx_valid}, 32'd1);
        pop();

        // Reset in the middle of a looped-back frame.
        loop_en    = 1'b1;
        data_bits  = 4'd8;
        pmode      = 2'b00;
        extra_stop = 1'b0;
        send(8'hC3);
        repeat (60) @(negedge clk);
        chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_tx_o", {31'd0, tx_o}, 32'd1);
        chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_no_word", {31'd0, rx_valid}, 32'd0);
        loop_frame(8'h96, 8, 0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
